// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin burst-limited arbiter driving a 4:1 single-bit mux
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] last, last_nxt;
    logic [3:0] cnt, cnt_nxt, cnt_inc;
    logic       y_nxt, yv_nxt;
    logic       rel;
    logic [2:0] pick, hand;

    // Returns {found, index}: first requester after l, wrapping modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = l + 2'(i);
            if (r[idx] && !res[2]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            last    <= 2'd3;
            cnt     <= 4'd0;
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            y_valid <= yv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        cnt_nxt   = cnt;
        y_nxt     = y;
        yv_nxt    = 1'b0;
        rel       = 1'b0;
        cnt_inc   = cnt + 4'd1;
        pick      = rr_pick(req, last);
        // Handover pick treats the outgoing owner as last and masks its own request.
        hand      = rr_pick(req & ~gnt, sel);
        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick[1:0];
                    gnt_nxt   = 4'b0001 << pick[1:0];
                    cnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    rel = 1'b1;
                end else begin
                    y_nxt  = din[sel];
                    yv_nxt = 1'b1;
                    if (cnt_inc == 4'(MAX_BURST)) begin
                        if ((req & ~gnt) != 4'b0000) rel = 1'b1;
                        else cnt_nxt = 4'd0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                if (rel) begin
                    last_nxt = sel;
                    cnt_nxt  = 4'd0;
                    if (hand[2]) begin
                        sel_nxt = hand[1:0];
                        gnt_nxt = 4'b0001 << hand[1:0];
                    end else begin
                        gnt_nxt   = 4'b0000;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == GRANT);
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4:1 single-bit mux datapath. Four requesters each present one data bit and a request line. The block grants exactly one requester at a time and drives the 2-bit mux select from the grant. It registers the selected bit with a valid strobe, so downstream logic sees a clean serialised stream. Grant tenure is bounded by a burst limit, so no requester can starve the others.

Parameters:
MAX_BURST, 4, maximum consecutive transfer cycles per grant while other requests are pending (legal range 1..15)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request per requester; bit n = requester n
din  input  4  data bit per requester; din[n] is the mux input i[n]
gnt  output 4  one-hot grant, registered; all-zero when idle
sel  output 2  mux select, equals binary index of gnt; holds last value when idle
y  output 1  registered muxed data bit
y_valid  output 1  high for exactly the cycles y carries a fresh transfer
busy  output 1  high while state is GRANT

Behaviour:
- Reset: synchronous and active-high, sampled on the clk rising edge, and takes priority over everything else. After reset:
  - gnt=0000, sel=00, y=0, y_valid=0, busy=0.
  - State IDLE, burst counter=0, last-owner pointer=3, so requester 0 has first priority.
- Reset asserted mid-GRANT: the next edge forces the reset values. No transfer completes on that edge; y_valid=0.
- Round-robin pick: search indices last+1, last+2, ... modulo 4 and take the first with req set.
- State IDLE:
  - If req==0000, remain in IDLE.
  - Otherwise, on the next edge: owner=pick, gnt=onehot(owner), sel=owner, busy=1, counter=0, go to GRANT.
  - No transfer occurs on this edge; y_valid=0.
- State GRANT, with owner k. Each edge evaluates the following in order:
  1. req[k]=0: release, no transfer, y_valid=0, last=k.
  2. Otherwise, transfer: y<=din[k], y_valid<=1, counter<=counter+1.
  3. If the post-increment counter equals MAX_BURST and any req[j]=1 for j≠k: release after this transfer, last=k.
  4. If the counter reaches MAX_BURST and no other request is pending: keep the grant, counter<=0, continue. Bursts restart indefinitely.
- Release handover on the same edge:
  - Compute the next pick using the updated last=k and the current req with bit k masked.
  - If a pick exists: gnt/sel switch directly to it, counter=0, stay in GRANT. There is no dead cycle.
  - Otherwise: gnt=0000, busy=0, go to IDLE. sel retains its value.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Grant to first y_valid: 1 cycle. The first edge with gnt high samples din.
  - y reflects din[sel] at the previous edge.
- y holds its value when y_valid=0.
- Invariants:
  - gnt is always one-hot or zero.
  - sel==index(gnt) whenever gnt≠0.
  - busy==(gnt≠0).
- Simultaneous events:
  - All four requesting from reset: order is 0,1,2,3,0,...
  - A new request arriving on the release edge participates in that edge's pick.
  - Requester k re-raising req on its own release edge is masked. It waits for its next turn.
- The counter is 4 bits wide and never exceeds MAX_BURST.

Test Plan:
1. Reset behaviour: hold rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, y=0, y_valid=0, busy=0. Release rst -> next edge gnt=0001, sel=00.
2. Single requester streaming: req=0100, din=0100 for 6 cycles, then req=0000 -> gnt=0100 one cycle after req. y_valid high for 6 cycles with y=1; counter wraps at 4 without losing the grant. One cycle after req drops: gnt=0000, busy=0.
3. Burst fairness: req=1111, din=1010, MAX_BURST=4 -> grants 0001 ×4 transfers, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again. There is no gap cycle between owners. The y sequence per owner is 0,1,0,1.
4. Early release and handover: owner 1 active, req=0011 dropping to 0001 after 2 transfers -> the next edge has gnt=0001 with no transfer that edge. The following edge has y_valid=1, y=din[0].
5. Mid-operation reset: req=1111 with owner 2 granted; assert rst for 1 cycle -> all outputs return to reset values. Restart grants requester 0, not 3.
6. Mux equivalence check: exhaustive din 0000..1111 with a single requester n=0..3 -> y matches the reference mux output for i=din, s=n on every y_valid cycle.
